// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet framing constants and the receive deframer state type
package eth_pkg;
  localparam logic [3:0] ETH_PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] ETH_SFD_NIB = 4'hD;
  localparam logic [31:0] CRC32_POLY_R = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
  typedef enum logic [1:0] {ST_IDLE, ST_PREAMBLE, ST_PAYLOAD, ST_DROP} rx_deframer_state_t;
endpackage

// File: rtl/eth_crc32_byte.sv
// eth_crc32_byte: combinational reflected CRC-32 update over one byte
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  always_comb begin
    crc_out = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) crc_out = crc_out[0] ? (crc_out >> 1) ^ CRC32_POLY_R : crc_out >> 1;
  end
endmodule

// File: rtl/mii_rx_deframer.sv
// mii_rx_deframer: MII nibble stream to byte AXI-Stream with preamble strip, FCS check and error tagging
module mii_rx_deframer
  import eth_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic       mii_rx_clk,
  input  logic       rst,
  input  logic [3:0] mii_rxd,
  input  logic       mii_rx_dv,
  input  logic       mii_rx_er,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  output logic       m_axis_tlast,
  output logic       m_axis_tuser,
  output logic       stat_good,
  output logic       stat_bad_fcs,
  output logic       stat_bad_frame
);
  rx_deframer_state_t state;
  logic [31:0] crc, crc_next;
  logic [10:0] len;
  logic [3:0]  low;
  logic [7:0]  hold, rx_byte;
  logic        hi, hold_valid, rx_err, frame_err, crc_err;
  assign rx_byte = {mii_rxd, low};
  assign crc_err = crc != CRC32_RESIDUE;
  assign frame_err = hi | rx_err | mii_rx_er | (len < 11'(MIN_LEN)) | (len > 11'(MAX_LEN));
  eth_crc32_byte u_crc (.crc_in(crc), .data(rx_byte), .crc_out(crc_next));
  always_ff @(posedge mii_rx_clk) begin
    m_axis_tvalid <= 1'b0;
    m_axis_tdata <= 8'd0;
    m_axis_tlast <= 1'b0;
    m_axis_tuser <= 1'b0;
    stat_good <= 1'b0;
    stat_bad_fcs <= 1'b0;
    stat_bad_frame <= 1'b0;
    if (rst) begin
      state <= ST_IDLE;
      crc <= CRC32_INIT;
      len <= 11'd0;
      low <= 4'd0;
      hi <= 1'b0;
      hold <= 8'd0;
      hold_valid <= 1'b0;
      rx_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (mii_rx_dv) state <= mii_rxd == ETH_PREAMBLE_NIB ? ST_PREAMBLE : ST_DROP;
        ST_PREAMBLE:
          if (!mii_rx_dv) state <= ST_IDLE;
          else if (mii_rxd == ETH_SFD_NIB) begin
            state <= ST_PAYLOAD;
            crc <= CRC32_INIT;
            len <= 11'd0;
            hi <= 1'b0;
            hold_valid <= 1'b0;
            rx_err <= 1'b0;
          end else if (mii_rxd != ETH_PREAMBLE_NIB) state <= ST_DROP;
        ST_PAYLOAD:
          if (!mii_rx_dv) begin
            state <= ST_IDLE;
            hold_valid <= 1'b0;
            m_axis_tvalid <= hold_valid;
            m_axis_tlast <= hold_valid;
            m_axis_tdata <= hold_valid ? hold : 8'd0;
            m_axis_tuser <= hold_valid & (frame_err | crc_err);
            stat_good <= hold_valid & ~frame_err & ~crc_err;
            stat_bad_fcs <= hold_valid & ~frame_err & crc_err;
            stat_bad_frame <= ~hold_valid | frame_err;
          end else begin
            rx_err <= rx_err | mii_rx_er;
            hi <= ~hi;
            if (!hi) low <= mii_rxd;
            else begin
              crc <= crc_next;
              len <= &len ? len : len + 11'd1;
              hold <= rx_byte;
              hold_valid <= 1'b1;
              m_axis_tvalid <= hold_valid;
              m_axis_tdata <= hold_valid ? hold : 8'd0;
            end
          end
        ST_DROP: if (!mii_rx_dv) state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mii_rx_deframer.sv
// tb_mii_rx_deframer: directed frames with bench-computed FCS, byte stream and stat checks
module tb_mii_rx_deframer;
  logic clk = 0, rst = 1, dv = 0, er = 0;
  logic [3:0] rxd = 0;
  logic [7:0] tdata;
  logic tvalid, tlast, tuser, stat_good, stat_bad_fcs, stat_bad_frame;
  always #5 clk = ~clk;
  mii_rx_deframer dut (
    .mii_rx_clk(clk), .rst(rst), .mii_rxd(rxd), .mii_rx_dv(dv), .mii_rx_er(er),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast), .m_axis_tuser(tuser),
    .stat_good(stat_good), .stat_bad_fcs(stat_bad_fcs), .stat_bad_frame(stat_bad_frame)
  );
  int checks = 0, failures = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  logic [7:0] rxq[$], fr[$], exp_q[$];
  int nlast = 0, last_pos = 0, ngood = 0, nfcs = 0, nbad = 0, junk = 0, multi = 0;
  logic tu = 0;
  always @(negedge clk) begin
    if (tvalid) begin
      rxq.push_back(tdata);
      if (tlast) begin
        nlast++;
        last_pos = rxq.size();
        tu = tuser;
      end
    end else if (tdata != 0 || tlast || tuser) junk++;
    ngood += int'(stat_good);
    nfcs += int'(stat_bad_fcs);
    nbad += int'(stat_bad_frame);
    if (int'(stat_good) + int'(stat_bad_fcs) + int'(stat_bad_frame) > 1) multi++;
  end
  int b_rx, b_last, b_good, b_fcs, b_bad, b_junk, b_multi;
  task automatic snap();
    b_rx = rxq.size(); b_last = nlast; b_good = ngood; b_fcs = nfcs; b_bad = nbad; b_junk = junk; b_multi = multi;
  endtask
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  task automatic build_frame(input int n, input int seed);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    fr.delete();
    for (int i = 0; i < n - 4; i++) begin
      fr.push_back(8'((i * 37 + seed * 101 + 11) ^ (i >> 3)));
      c = crc_upd(c, fr[i]);
    end
    c = ~c;
    for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
  endtask
  task automatic nib(input logic [3:0] n, input logic e);
    @(negedge clk);
    dv = 1; rxd = n; er = e;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      dv = 0; rxd = 0; er = 0;
    end
  endtask
  task automatic preamble();
    repeat (15) nib(4'h5, 0);
    nib(4'hD, 0);
  endtask
  task automatic send_bytes(input int n, input int er_byte);
    for (int i = 0; i < n; i++) begin
      nib(fr[i][3:0], i == er_byte);
      nib(fr[i][7:4], 0);
    end
  endtask
  task automatic send_frame(input int er_byte, input bit odd);
    preamble();
    send_bytes(fr.size(), er_byte);
    if (odd) nib(4'h3, 0);
    idle(1);
  endtask
  task automatic verify(input string tag, input int n, input int nl, input logic tu_exp, input int g, input int f, input int b);
    int mism;
    idle(3);
    mism = 0;
    chk({tag, "_len"}, rxq.size() - b_rx, n);
    for (int i = 0; i < n && b_rx + i < rxq.size(); i++) if (rxq[b_rx + i] !== exp_q[i]) mism++;
    chk({tag, "_data"}, mism, 0);
    chk({tag, "_nlast"}, nlast - b_last, nl);
    if (nl > 0) begin
      chk({tag, "_lastpos"}, last_pos, b_rx + n);
      chk({tag, "_tuser"}, tu, tu_exp);
    end
    chk({tag, "_good"}, ngood - b_good, g);
    chk({tag, "_badfcs"}, nfcs - b_fcs, f);
    chk({tag, "_badframe"}, nbad - b_bad, b);
    chk({tag, "_junk"}, junk - b_junk, 0);
    chk({tag, "_multi"}, multi - b_multi, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out", {tdata, tvalid, tlast, tuser, stat_good, stat_bad_fcs, stat_bad_frame}, 0);
    rst = 0;
    idle(2);
    snap(); build_frame(64, 1); exp_q = fr;
    send_frame(-1, 0);
    verify("good64", 64, 1, 0, 1, 0, 0);
    snap(); build_frame(64, 1); fr[10] = fr[10] ^ 8'h04; exp_q = fr;
    send_frame(-1, 0);
    verify("bitflip", 64, 1, 1, 0, 1, 0);
    snap(); build_frame(63, 2); exp_q = fr;
    send_frame(-1, 0);
    verify("runt63", 63, 1, 1, 0, 0, 1);
    snap(); build_frame(1523, 3); exp_q = fr;
    send_frame(-1, 0);
    verify("over1523", 1523, 1, 1, 0, 0, 1);
    snap(); build_frame(64, 4); exp_q = fr;
    send_frame(20, 0);
    verify("rx_er", 64, 1, 1, 0, 0, 1);
    snap(); build_frame(64, 5); exp_q = fr;
    send_frame(-1, 1);
    verify("odd_nib", 64, 1, 1, 0, 0, 1);
    snap(); build_frame(64, 6); exp_q = fr;
    send_frame(-1, 0);
    build_frame(70, 7);
    foreach (fr[i]) exp_q.push_back(fr[i]);
    send_frame(-1, 0);
    verify("b2b", 134, 2, 0, 2, 0, 0);
    snap(); build_frame(64, 8); exp_q = fr;
    nib(4'hA, 0);
    repeat (14) nib(4'h5, 0);
    nib(4'hD, 0);
    send_bytes(64, -1);
    idle(1);
    verify("drop", 0, 0, 0, 0, 0, 0);
    snap();
    preamble();
    idle(1);
    verify("empty", 0, 0, 0, 0, 0, 1);
    snap(); build_frame(64, 9); exp_q = fr;
    preamble();
    send_bytes(30, -1);
    @(negedge clk);
    rst = 1; dv = 1; rxd = 0;
    @(negedge clk);
    chk("rst_mid_out", {tdata, tvalid, tlast, tuser, stat_good, stat_bad_fcs, stat_bad_frame}, 0);
    rst = 0;
    repeat (3) nib(4'h0, 0);
    idle(1);
    verify("rst_mid", 29, 0, 0, 0, 0, 0);
    snap(); build_frame(64, 10); exp_q = fr;
    send_frame(-1, 0);
    verify("after_rst", 64, 1, 0, 1, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
